// File: rtl/reset_sequencer.sv
// Power-up reset sequencer: filters PLL lock, holds all domain resets for a
// minimum time, then releases them one by one (bit 0 first) and flags done.
module reset_sequencer #(
  parameter int NUM_STAGES  = 3,
  parameter int LOCK_FILTER = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pll_locked,
  input  logic                  sw_rst_req,
  output logic [NUM_STAGES-1:0] rst_stage_out,
  output logic                  rst_done,
  output logic [1:0]            state_dbg,
  output logic [7:0]            lock_lost_cnt
);

  localparam int MAX_AB  = (LOCK_FILTER > HOLD_CYCLES) ? LOCK_FILTER : HOLD_CYCLES;
  localparam int MAX_CNT = (MAX_AB > STAGE_GAP) ? MAX_AB : STAGE_GAP;
  localparam int CW      = $clog2(MAX_CNT) + 1;
  localparam int IW      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CW-1:0] LF_LAST  = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] HC_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] SG_LAST  = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t                state_reg, state_next;
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic [IW-1:0]         idx_reg, idx_next;
  logic [NUM_STAGES-1:0] stage_reg, stage_next;
  logic                  done_reg, done_next;
  logic [7:0]            llc_reg, llc_next;

  logic                  abort;
  logic                  rel_en;
  logic [IW-1:0]         rel_idx;
  logic                  abort_req;

  assign abort_req = !pll_locked || sw_rst_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= WAIT_LOCK;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      stage_reg <= '1;
      done_reg  <= 1'b0;
      llc_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      stage_reg <= stage_next;
      done_reg  <= done_next;
      llc_reg   <= llc_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    done_next  = done_reg;
    llc_next   = llc_reg;
    abort      = 1'b0;
    rel_en     = 1'b0;
    rel_idx    = '0;

    case (state_reg)
      WAIT_LOCK: begin
        // Any glitch restarts the lock filter from zero.
        if (abort_req) begin
          cnt_next = '0;
        end else if (cnt_reg == LF_LAST) begin
          state_next = HOLD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      HOLD: begin
        if (abort_req) begin
          abort = 1'b1;
        end else if (cnt_reg == HC_LAST) begin
          cnt_next = '0;
          rel_en   = 1'b1;
          rel_idx  = '0;
          if (NUM_STAGES == 1) begin
            state_next = RUN;
            done_next  = 1'b1;
          end else begin
            state_next = RELEASE;
          end
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      RELEASE: begin
        // idx_reg names the most recently released stage.
        if (abort_req) begin
          abort = 1'b1;
        end else if (cnt_reg == SG_LAST) begin
          cnt_next = '0;
          rel_en   = 1'b1;
          rel_idx  = idx_reg + IDX_ONE;
          idx_next = idx_reg + IDX_ONE;
          if (idx_reg + IDX_ONE == IDX_LAST) begin
            state_next = RUN;
            done_next  = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      RUN: begin
        if (abort_req) begin
          abort = 1'b1;
        end
      end
      default: begin
        abort = 1'b1;
      end
    endcase

    if (abort) begin
      state_next = WAIT_LOCK;
      cnt_next   = '0;
      idx_next   = '0;
      done_next  = 1'b0;
      // A combined lock-loss + software request still counts as one loss.
      if (!pll_locked && llc_reg != 8'hFF) begin
        llc_next = llc_reg + 8'd1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
      always_comb begin
        stage_next[gi] = stage_reg[gi];
        if (abort || state_reg == WAIT_LOCK) begin
          stage_next[gi] = 1'b1;
        end else if (rel_en && rel_idx == IW'(gi)) begin
          stage_next[gi] = 1'b0;
        end
      end
    end
  endgenerate

  assign rst_stage_out = stage_reg;
  assign rst_done      = done_reg;
  assign state_dbg     = state_reg;
  assign lock_lost_cnt = llc_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: stimulus queues expected outputs per
// clock edge, a negedge monitor pops and compares them against two instances.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       sw_rst_req;

  logic [2:0] stage_a;
  logic       done_a;
  logic [1:0] st_a;
  logic [7:0] llc_a;
  logic [0:0] stage_b;
  logic       done_b;
  logic [1:0] st_b;
  logic [7:0] llc_b;

  always #5 clk = ~clk;

  reset_sequencer #(.NUM_STAGES(3)) dut_a (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .sw_rst_req(sw_rst_req),
    .rst_stage_out(stage_a), .rst_done(done_a), .state_dbg(st_a), .lock_lost_cnt(llc_a)
  );

  reset_sequencer #(.NUM_STAGES(1)) dut_b (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .sw_rst_req(sw_rst_req),
    .rst_stage_out(stage_b), .rst_done(done_b), .state_dbg(st_b), .lock_lost_cnt(llc_b)
  );

  typedef struct {
    int         cyc;
    int         dut;
    string      name;
    logic [2:0] stage;
    logic       done;
    logic [1:0] st;
    logic [7:0] llc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   finish_req = 1'b0;

  logic [2:0] m_stage;
  logic       m_done;
  logic [1:0] m_st;
  logic [7:0] m_llc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_at(input int c, input int d, input string nm,
                           input logic [2:0] s, input logic dn,
                           input logic [1:0] st, input logic [7:0] l);
    exp_t e;
    e.cyc = c; e.dut = d; e.name = nm;
    e.stage = s; e.done = dn; e.st = st; e.llc = l;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compares every queued expectation whose edge has just occurred.
  always @(negedge clk) begin
    if (finish_req) begin
      n_cmp++;
      if (sb.size() != 0) begin
        n_bad++;
        $display("FAIL sb_leftover: got %0d pending entries, want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        if (sb[i].dut == 0) begin
          m_stage = stage_a; m_done = done_a; m_st = st_a; m_llc = llc_a;
        end else begin
          m_stage = {2'b00, stage_b}; m_done = done_b; m_st = st_b; m_llc = llc_b;
        end
        n_cmp++;
        if (m_stage !== sb[i].stage || m_done !== sb[i].done ||
            m_st !== sb[i].st || m_llc !== sb[i].llc) begin
          n_bad++;
          $display("FAIL %s edge=%0d dut%0d: got stage=%b done=%b st=%0d llc=%0d, want stage=%b done=%b st=%0d llc=%0d",
                   sb[i].name, cyc, sb[i].dut, m_stage, m_done, m_st, m_llc,
                   sb[i].stage, sb[i].done, sb[i].st, sb[i].llc);
        end else begin
          $display("chk  %s edge=%0d dut%0d stage=%b done=%b st=%0d llc=%0d",
                   sb[i].name, cyc, sb[i].dut, m_stage, m_done, m_st, m_llc);
        end
        sb.delete(i);
      end
    end
    // Ordering invariant: only thermometer patterns, and done implies all released.
    if (cyc > 0) begin
      n_cmp++;
      if (!(stage_a == 3'b111 || stage_a == 3'b110 || stage_a == 3'b100 || stage_a == 3'b000) ||
          (done_a && stage_a != 3'b000)) begin
        n_bad++;
        $display("FAIL invariant edge=%0d: got stage=%b done=%b, want thermometer order and done->0",
                 cyc, stage_a, done_a);
      end
    end
  end

  initial begin
    int b;
    int p;
    int c;
    int d;
    int e;
    int f;
    rst = 1'b1;
    pll_locked = 1'b1;
    sw_rst_req = 1'b0;

    // Reset values
    tick(3);
    expect_at(cyc + 1, 0, "rst_state", 3'b111, 1'b0, 2'd0, 8'd0);
    expect_at(cyc + 1, 1, "rst_state", 3'b001, 1'b0, 2'd0, 8'd0);
    tick(2);

    // Test 1: nominal release timing (both stage counts)
    rst = 1'b0;
    b = cyc;
    expect_at(b + 3,  0, "t1_wait",   3'b111, 1'b0, 2'd0, 8'd0);
    expect_at(b + 4,  0, "t1_hold",   3'b111, 1'b0, 2'd1, 8'd0);
    expect_at(b + 19, 0, "t1_prerel", 3'b111, 1'b0, 2'd1, 8'd0);
    expect_at(b + 20, 0, "t1_s0",     3'b110, 1'b0, 2'd2, 8'd0);
    expect_at(b + 27, 0, "t1_pre_s1", 3'b110, 1'b0, 2'd2, 8'd0);
    expect_at(b + 28, 0, "t1_s1",     3'b100, 1'b0, 2'd2, 8'd0);
    expect_at(b + 35, 0, "t1_pre_s2", 3'b100, 1'b0, 2'd2, 8'd0);
    expect_at(b + 36, 0, "t1_done",   3'b000, 1'b1, 2'd3, 8'd0);
    expect_at(b + 19, 1, "t1b_hold",  3'b001, 1'b0, 2'd1, 8'd0);
    expect_at(b + 20, 1, "t1b_done",  3'b000, 1'b1, 2'd3, 8'd0);
    tick(40);

    // Test 3: lock loss in RUN, full sequence repeats
    p = cyc;
    pll_locked = 1'b0;
    expect_at(p + 1,  0, "t3_abort",  3'b111, 1'b0, 2'd0, 8'd1);
    expect_at(p + 1,  1, "t3b_abort", 3'b001, 1'b0, 2'd0, 8'd1);
    expect_at(p + 20, 0, "t3_hold",   3'b111, 1'b0, 2'd1, 8'd1);
    expect_at(p + 21, 0, "t3_s0",     3'b110, 1'b0, 2'd2, 8'd1);
    expect_at(p + 36, 0, "t3_pre",    3'b100, 1'b0, 2'd2, 8'd1);
    expect_at(p + 37, 0, "t3_done",   3'b000, 1'b1, 2'd3, 8'd1);
    expect_at(p + 21, 1, "t3b_done",  3'b000, 1'b1, 2'd3, 8'd1);
    tick(1);
    pll_locked = 1'b1;
    tick(40);

    // Test 2: lock glitch in WAIT_LOCK restarts the filter
    rst = 1'b1;
    expect_at(cyc + 1, 0, "t2_rst", 3'b111, 1'b0, 2'd0, 8'd0);
    tick(2);
    rst = 1'b0;
    b = cyc;
    expect_at(b + 4,  0, "t2_glitch", 3'b111, 1'b0, 2'd0, 8'd0);
    expect_at(b + 7,  0, "t2_refilt", 3'b111, 1'b0, 2'd0, 8'd0);
    expect_at(b + 8,  0, "t2_hold",   3'b111, 1'b0, 2'd1, 8'd0);
    expect_at(b + 23, 0, "t2_prerel", 3'b111, 1'b0, 2'd1, 8'd0);
    expect_at(b + 24, 0, "t2_s0",     3'b110, 1'b0, 2'd2, 8'd0);
    expect_at(b + 24, 1, "t2b_done",  3'b000, 1'b1, 2'd3, 8'd0);
    tick(3);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(21);

    // Test 4: combined lock loss + sw request in RELEASE counts once
    c = cyc;
    pll_locked = 1'b0;
    sw_rst_req = 1'b1;
    expect_at(c + 1,  0, "t4_both",   3'b111, 1'b0, 2'd0, 8'd1);
    expect_at(c + 1,  1, "t4b_both",  3'b001, 1'b0, 2'd0, 8'd1);
    expect_at(c + 37, 0, "t4_done",   3'b000, 1'b1, 2'd3, 8'd1);
    tick(1);
    pll_locked = 1'b1;
    sw_rst_req = 1'b0;
    tick(40);

    // Test 4b: sw-only request in RUN leaves the loss counter alone
    d = cyc;
    sw_rst_req = 1'b1;
    expect_at(d + 1,  0, "t4_sw",     3'b111, 1'b0, 2'd0, 8'd1);
    expect_at(d + 1,  1, "t4b_sw",    3'b001, 1'b0, 2'd0, 8'd1);
    expect_at(d + 37, 0, "t4_swdone", 3'b000, 1'b1, 2'd3, 8'd1);
    tick(1);
    sw_rst_req = 1'b0;
    tick(40);

    // Test 5: raise count to 3, then rst mid-RELEASE clears everything
    e = cyc;
    pll_locked = 1'b0;
    expect_at(e + 1, 0, "t5_loss2", 3'b111, 1'b0, 2'd0, 8'd2);
    tick(1);
    pll_locked = 1'b1;
    tick(10);
    f = cyc;
    pll_locked = 1'b0;
    expect_at(f + 1,  0, "t5_loss3", 3'b111, 1'b0, 2'd0, 8'd3);
    expect_at(f + 29, 0, "t5_s1",    3'b100, 1'b0, 2'd2, 8'd3);
    expect_at(f + 30, 0, "t5_pre",   3'b100, 1'b0, 2'd2, 8'd3);
    tick(1);
    pll_locked = 1'b1;
    tick(29);
    rst = 1'b1;
    expect_at(cyc + 1, 0, "t5_rst",  3'b111, 1'b0, 2'd0, 8'd0);
    expect_at(cyc + 1, 1, "t5b_rst", 3'b001, 1'b0, 2'd0, 8'd0);
    tick(2);

    // Test 6: 300 lock losses from RUN saturate the counter at 255
    rst = 1'b0;
    b = cyc;
    expect_at(b + 36, 0, "t6_run", 3'b000, 1'b1, 2'd3, 8'd0);
    tick(37);
    for (int i = 0; i < 300; i++) begin
      p = cyc;
      pll_locked = 1'b0;
      expect_at(p + 1, 0, $sformatf("t6_loss%0d", i + 1), 3'b111, 1'b0, 2'd0,
                (i + 1 > 255) ? 8'd255 : 8'(i + 1));
      tick(1);
      pll_locked = 1'b1;
      tick(36);
    end
    expect_at(cyc + 1, 0, "t6_hold",  3'b000, 1'b1, 2'd3, 8'd255);
    expect_at(cyc + 1, 1, "t6b_hold", 3'b000, 1'b1, 2'd3, 8'd255);
    tick(3);
    finish_req = 1'b1;
    tick(3);
    $display("FAIL watchdog: got no summary, want monitor to finish");
    $fatal(1, "monitor did not finish");
  end

endmodule
